ifetch_unit: RTL
================

IFETCH_UNIT -- requirements
Module: ifetch_unit

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning number of buffer slots (power of two, 2..16).
REQ-002 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning first fetch address after reset.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port req_valid  output  1  instruction-memory request valid.
REQ-006 SHALL have port req_addr  output  32  request word address (byte address, bits [1:0] = 0).
REQ-007 SHALL have port req_ready  input  1  memory accepts request this cycle.
REQ-008 SHALL have port resp_valid  input  1  memory returns one instruction word, strictly in request order.
REQ-009 SHALL have port resp_data  input  32  returned instruction word.
REQ-010 SHALL have port redirect  input  1  flush and restart fetch at redirect_pc (branch/jump taken).
REQ-011 SHALL have port redirect_pc  input  32  new fetch address; bits [1:0] ignored and treated as 0.
REQ-012 SHALL have port instr_valid  output  1  head instruction available to decode/immediate stage.
REQ-013 SHALL have port instr  output  32  head instruction word.
REQ-014 SHALL have port instr_pc  output  32  address of head instruction.
REQ-015 SHALL have port instr_ready  input  1  downstream consumes head this cycle.

Function
REQ-016 SHALL hold fetch PC fpc; req_addr = fpc; fpc += 4 (mod 2^32, wrap 0xFFFF_FFFC -> 0) on each req_valid & req_ready.
REQ-017 SHALL keep an in-order circular buffer of DEPTH slots {pc, data, filled}; a slot is allocated with pc = fpc on request acceptance, filled on a non-dropped response.
REQ-018 SHALL keep drop_cnt (log2(DEPTH)+1 bits) of stale outstanding requests; a response while drop_cnt > 0 is discarded and drop_cnt decrements.
REQ-019 SHALL assert req_valid iff !redirect and (allocated + drop_cnt) < DEPTH, using registered counts only (a slot freed this cycle is not reusable until next cycle).
REQ-020 SHALL fill the oldest unfilled slot on a non-dropped resp_valid; resp_valid with nothing outstanding SHALL be ignored with no state change.
REQ-021 SHALL drive instr_valid = head slot allocated and filled; instr/instr_pc from head slot; combinational from registers, no input-to-output path.
REQ-022 SHALL pop head on instr_valid & instr_ready; pop and fill/allocate in the same cycle SHALL all take effect.
REQ-023 SHALL on redirect: free all slots, set fpc = {redirect_pc[31:2],2'b00}, set drop_cnt = old drop_cnt + unfilled allocated slots - (1 if a response arrives that cycle), suppress req_valid that cycle.
REQ-024 SHALL ignore instr_ready in a redirect cycle (no pop); instr_valid SHALL be 0 in the cycle after a redirect.
REQ-025 SHALL deliver first instruction with latency 1 cycle after the response cycle (instr_valid rises the cycle after resp_valid).
REQ-026 SHALL sustain one instruction per cycle when memory returns one response per cycle and instr_ready is held high.

Reset
REQ-027 SHALL on rst set fpc = RESET_PC, free all slots, drop_cnt = 0, req_valid = 0, instr_valid = 0, instr = 0, instr_pc = 0; rst overrides redirect.
REQ-028 SHALL, on rst mid-operation, discard all outstanding state; the memory SHALL be reset in the same cycle so no stale responses arrive.
REQ-029 SHALL assert req_valid no earlier than the first cycle after rst deasserts.

Configuration
REQ-030 SHALL, with IFETCH_STALL_CNT_EN defined, add output stall_cnt (32 bits, reset 0) incrementing (wrapping) every non-reset cycle with instr_valid = 0 and instr_ready = 1.
REQ-031 SHALL, without IFETCH_STALL_CNT_EN, omit port stall_cnt and its counter; all other behaviour identical.

Verification
REQ-032 Reset, RESET_PC=0, req_ready=1, 1-cycle memory returning addr as data, instr_ready=1 -> instr_pc 0,4,8,... one per cycle, instr = instr_pc.
REQ-033 instr_ready=0, req_ready=1, DEPTH=4 -> exactly 4 requests (0,4,8,12) accepted, req_valid then 0, instr_valid held with instr_pc=0.
REQ-034 Redirect to 0x100 with 3 unfilled outstanding -> next 3 responses dropped, next instr_pc = 0x100, no stale instruction visible.
REQ-035 Redirect with redirect_pc = 0x203 in same cycle as response and instr_ready=1 -> no pop, response counted as dropped, fetch resumes at 0x200.
REQ-036 fpc = 0xFFFF_FFFC accepted -> next req_addr = 0x0000_0000; assert rst mid-burst -> next cycle all outputs at reset values, refetch from RESET_PC.
REQ-037 With IFETCH_STALL_CNT_EN, memory holding resp 5 cycles after reset, instr_ready=1 -> stall_cnt = 6 when first instr_valid rises.

Source files
------------

// File: rtl/ifetch_unit.sv
// ifetch_unit: instruction fetch front end with an in-order fetch buffer.
//
// Issues word-aligned fetch requests from a fetch PC and tracks each accepted
// request in a circular buffer of DEPTH slots. Responses arrive in request
// order and fill the oldest unfilled slot. The head slot is presented to
// decode once it is filled. A redirect frees every slot, restarts fetch at
// redirect_pc and turns still-outstanding requests into responses that must
// be discarded on arrival.
//
// Optional feature macro: IFETCH_STALL_CNT_EN adds a 32-bit stall counter
// output that counts cycles where decode is ready but no instruction is valid.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   req_valid/req_addr        fetch request to instruction memory
//   req_ready                 memory accepts the request this cycle
//   resp_valid/resp_data      in-order instruction word from memory
//   redirect/redirect_pc      flush and restart fetch at a new address
//   instr_valid/instr/
//   instr_pc                  head instruction presented to decode
//   instr_ready               decode consumes the head this cycle
//   stall_cnt                 (IFETCH_STALL_CNT_EN only) starvation counter
module ifetch_unit #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        req_valid,
  output logic [31:0] req_addr,
  input  logic        req_ready,
  input  logic        resp_valid,
  input  logic [31:0] resp_data,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready
`ifdef IFETCH_STALL_CNT_EN
  ,
  output logic [31:0] stall_cnt
`endif
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  logic [31:0]   r_fpc;
  logic [31:0]   r_pc   [DEPTH];
  logic [31:0]   r_data [DEPTH];
  logic [AW-1:0] r_head;
  logic [CW-1:0] r_count;    // allocated slots
  logic [CW-1:0] r_nfilled;  // filled slots; always the oldest ones
  logic [CW-1:0] r_drop;     // stale outstanding responses to discard

  logic [CW-1:0] w_unfilled;
  logic [CW-1:0] w_outstanding;
  logic          w_space;
  logic          w_alloc;
  logic          w_resp_take;
  logic          w_resp_drop;
  logic          w_fill;
  logic          w_pop;
  logic [AW-1:0] w_tail;
  logic [AW-1:0] w_fill_idx;
  logic [31:0]   w_redirect_pc_aligned;

  // Request/response bookkeeping, all derived from registered counts
  always_comb begin
    w_unfilled            = r_count - r_nfilled;
    w_outstanding         = r_drop + w_unfilled;
    w_space               = (({1'b0, r_count} + {1'b0, r_drop}) < (CW+1)'(DEPTH));
    w_alloc               = req_valid && req_ready;
    // A response with nothing outstanding is ignored entirely
    w_resp_take           = resp_valid && (w_outstanding != '0);
    w_resp_drop           = w_resp_take && (r_drop != '0);
    w_fill                = w_resp_take && (r_drop == '0);
    w_pop                 = instr_valid && instr_ready && !redirect;
    w_tail                = r_head + AW'(r_count);
    w_fill_idx            = r_head + AW'(r_nfilled);
    w_redirect_pc_aligned = redirect_pc & 32'hFFFF_FFFC;
  end

  // Outputs: request side gated by rst/redirect, decode side from registers only
  always_comb begin
    req_valid   = !rst && !redirect && w_space;
    req_addr    = r_fpc;
    instr_valid = (r_nfilled != '0);
    instr       = instr_valid ? r_data[r_head] : 32'h0;
    instr_pc    = instr_valid ? r_pc[r_head]   : 32'h0;
  end

  // Control state: fetch PC, pointers, counters
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fpc     <= RESET_PC;
      r_head    <= '0;
      r_count   <= '0;
      r_nfilled <= '0;
      r_drop    <= '0;
    end else if (redirect) begin
      // Unfilled slots become stale; a response arriving now retires one of them
      r_fpc     <= w_redirect_pc_aligned;
      r_head    <= '0;
      r_count   <= '0;
      r_nfilled <= '0;
      r_drop    <= w_outstanding - CW'(w_resp_take);
    end else begin
      if (w_alloc) r_fpc <= r_fpc + 32'd4;
      if (w_pop) r_head <= r_head + AW'(1);
      r_count   <= r_count + CW'(w_alloc) - CW'(w_pop);
      r_nfilled <= r_nfilled + CW'(w_fill) - CW'(w_pop);
      if (w_resp_drop) r_drop <= r_drop - CW'(1);
    end
  end

  // Slot payload storage; contents only matter while the slot is counted
  always_ff @(posedge clk) begin
    if (w_alloc) r_pc[w_tail] <= r_fpc;
    if (w_fill && !rst && !redirect) r_data[w_fill_idx] <= resp_data;
  end

`ifdef IFETCH_STALL_CNT_EN
  // Counts cycles where decode could take an instruction but none is ready
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= 32'h0;
    end else if (!instr_valid && instr_ready) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule
